// File: rtl/fdivision_if.sv
// Handshake and operand/result bus between the sequencing controller and the
// iterative floating-point divider.
interface fdivision_if;
    logic        start;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;
    logic        zero;

    modport master (
        output start, a_operand, b_operand,
        input  busy, done, result, Exception, Overflow, Underflow, zero
    );

    modport slave (
        input  start, a_operand, b_operand,
        output busy, done, result, Exception, Overflow, Underflow, zero
    );
endinterface

// File: rtl/fdivision.sv
// Iterative IEEE-754 single-precision divider (a / b): restoring mantissa
// division retiring one quotient bit per clock, fixed latency for all inputs.
module fdivision (
    input logic        clk,
    input logic        rst,
    fdivision_if.slave bus
);
    localparam int         QBITS    = 26;
    localparam logic [4:0] CNT_LOAD = 5'(QBITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [23:0] significand(input logic [31:0] f);
        return {(f[30:23] != 8'd0), f[22:0]};
    endfunction

    function automatic logic is_exception(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) | (b[30:23] == 8'hFF) | (b[30:0] == 31'd0);
    endfunction

    state_t           state_r;
    logic [4:0]       cnt_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [24:0]      rem_r;
    logic [QBITS-1:0] quo_r;
    logic             busy_r;
    logic             done_r;
    logic [31:0]      result_r;
    logic             exc_r;
    logic             ovf_r;
    logic             unf_r;
    logic             zero_r;

    logic [24:0]      divisor_s;
    logic             ge_s;
    logic [24:0]      rem_sub_s;
    logic [24:0]      rem_next_s;

    logic             sign_s;
    logic             norm_s;
    logic [22:0]      mant_s;
    logic             guard_s;
    logic             sticky_s;
    logic [23:0]      mant_sum_s;
    logic             carry_s;
    logic [22:0]      mant_fin_s;
    logic [9:0]       exp_s;
    logic             exc_s;
    logic             zero_s;
    logic             ovf_s;
    logic             unf_s;
    logic [31:0]      res_s;

    // One restoring step: trial subtract, keep or restore, then shift.
    always_comb begin
        divisor_s  = {1'b0, significand(b_r)};
        ge_s       = (rem_r >= divisor_s);
        if (ge_s) begin
            rem_sub_s = rem_r - divisor_s;
        end else begin
            rem_sub_s = rem_r;
        end
        rem_next_s = rem_sub_s << 1;
    end

    // Normalise, round (ties truncate), build exponent, flags and result.
    always_comb begin
        sign_s   = a_r[31] ^ b_r[31];
        norm_s   = quo_r[25];
        mant_s   = 23'd0;
        guard_s  = 1'b0;
        sticky_s = 1'b0;
        if (norm_s) begin
            mant_s   = quo_r[24:2];
            guard_s  = quo_r[1];
            sticky_s = quo_r[0] | (rem_r != 25'd0);
        end else begin
            mant_s   = quo_r[23:1];
            guard_s  = quo_r[0];
            sticky_s = (rem_r != 25'd0);
        end

        mant_sum_s = {1'b0, mant_s} + {23'd0, guard_s & sticky_s};
        carry_s    = mant_sum_s[23];
        if (carry_s) begin
            mant_fin_s = 23'd0;
        end else begin
            mant_fin_s = mant_sum_s[22:0];
        end

        // 10-bit two's-complement exponent; bit 9 set means negative.
        exp_s  = {2'b00, a_r[30:23]} - {2'b00, b_r[30:23]} + 10'd126
               + {9'd0, norm_s} + {9'd0, carry_s};
        exc_s  = is_exception(a_r, b_r);
        zero_s = ~exc_s & (a_r[30:0] == 31'd0);
        ovf_s  = ~exp_s[9] & (exp_s >= 10'd255) & ~zero_s & ~exc_s;
        unf_s  = (exp_s[9] | (exp_s == 10'd0)) & ~zero_s & ~exc_s;

        if (exc_s) begin
            res_s = 32'd0;
        end else if (zero_s) begin
            res_s = {sign_s, 31'd0};
        end else if (ovf_s) begin
            res_s = {sign_s, 8'hFF, 23'd0};
        end else if (unf_s) begin
            res_s = {sign_s, 31'd0};
        end else begin
            res_s = {sign_s, exp_s[7:0], mant_fin_s};
        end
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 5'd0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            rem_r    <= 25'd0;
            quo_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
            exc_r    <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r      <= bus.a_operand;
                        b_r      <= bus.b_operand;
                        rem_r    <= {1'b0, significand(bus.a_operand)};
                        quo_r    <= '0;
                        cnt_r    <= CNT_LOAD;
                        busy_r   <= 1'b1;
                        result_r <= 32'd0;
                        exc_r    <= 1'b0;
                        ovf_r    <= 1'b0;
                        unf_r    <= 1'b0;
                        zero_r   <= 1'b0;
                        state_r  <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    quo_r <= {quo_r[QBITS-2:0], ge_s};
                    rem_r <= rem_next_s;
                    if (cnt_r == 5'd0) begin
                        state_r <= ROUND;
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                ROUND: begin
                    result_r <= res_s;
                    exc_r    <= exc_s;
                    ovf_r    <= ovf_s;
                    unf_r    <= unf_s;
                    zero_r   <= zero_s;
                    done_r   <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.Exception = exc_r;
    assign bus.Overflow  = ovf_r;
    assign bus.Underflow = unf_r;
    assign bus.zero      = zero_r;
endmodule

// File: doc/fdivision.md
Name: fdivision

Overview:
- Iterative IEEE-754 single-precision divider (result = a_operand / b_operand). It is the inverse operation to the team's combinational fmultiplication block and shares its flag set and simplified number handling.
- Restoring mantissa division retires one quotient bit per clock, so the block uses small area at fixed latency.
- Sits in the FP datapath next to fmultiplication, with a start/busy/done handshake to the sequencing controller.

Parameters:
- QBITS, 26, number of quotient bits produced: 1 integer, 23 mantissa, guard, 1 extra for normalisation. Fixed; not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- a_operand  in  32  dividend; latched when start is accepted
- b_operand  in  32  divisor; latched when start is accepted
- busy  out  1  high from the accepting edge until return to IDLE
- done  out  1  single-cycle pulse; result and flags are valid from this cycle on
- result  out  32  quotient; held until the next accept
- Exception  out  1  either exponent is 8'hFF, or b_operand[30:0] == 0
- Overflow  out  1  biased exponent >= 255
- Underflow  out  1  biased exponent <= 0
- zero  out  1  dividend is zero and Exception = 0

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy, done, result, Exception, Overflow, Underflow and zero all = 0; internal registers cleared. An in-flight operation is discarded and no done pulse is produced.
- State machine: IDLE -> DIVIDE (26 cycles) -> ROUND (1) -> DONE (1) -> IDLE.
- Accept: start=1 in IDLE at edge E0 latches both operands, sets busy=1, loads the counter with 25 and enters DIVIDE.
  - start is ignored in every other state.
  - Minimum spacing between accepts is 29 cycles.
- Latency is fixed for all inputs, including special cases:
  - done = 1 between edges E0+27 and E0+28.
  - busy drops at E0+28.
- Operand setup:
  - sign = a[31] ^ b[31].
  - Hidden bit = 1 if the exponent is nonzero, else 0.
  - A = {h_a, a[22:0]}, B = {h_b, b[22:0]}.
  - Denormals are treated only via the hidden bit; no further pre-normalisation.
- DIVIDE (restoring):
  - Partial remainder R is 25 bits wide and is initialised to A.
  - Each cycle: if R >= B, set the quotient bit to 1 and R = R - B, else the bit is 0; then R = R << 1; the quotient shifts left by 1.
  - The counter decrements each cycle; DIVIDE exits when the counter reaches 0.
  - Result: Q[25:0] = floor(A*2^25/B). sticky_r = (final R != 0).
- ROUND (one cycle, all results registered at the ROUND->DONE edge):
  - normalised = Q[25].
  - If normalised: mant = Q[24:2], guard = Q[1], sticky = Q[0] | sticky_r.
  - Else: mant = Q[23:1], guard = Q[0], sticky = sticky_r.
  - mantissa = mant + (guard & sticky). This matches the multiplier's rounding: a tie truncates; this is not round-to-nearest-even.
  - If rounding carries out of 23 bits: mantissa = 0 and exponent +1.
  - Exponent is computed as a 10-bit signed value: exp = Ea - Eb + 126 + normalised (+ carry).
- Flags:
  - Overflow = (exp >= 255) & !zero & !Exception.
  - Underflow = (exp <= 0) & !zero & !Exception.
  - zero = !Exception & (a[30:0] == 0).
- Result priority:
  1. Exception -> 32'd0
  2. zero -> {sign, 31'd0}
  3. Overflow -> {sign, 8'hFF, 23'd0}
  4. Underflow -> {sign, 31'd0}
  5. otherwise -> {sign, exp[7:0], mantissa}
- Holding: result and flags stay stable from DONE until the next accept edge, where they are cleared to 0.

Test Plan:
- 6.0/2.0: a=40C00000, b=40000000 -> at E0+27, done=1, result=40400000, all flags 0; busy falls at E0+28.
- 1.0/3.0: a=3F800000, b=40400000 -> result=3EAAAAAB (guard=1, sticky=1 rounds up); -1.0/3.0 -> BEAAAAAB.
- Specials:
  - a=3F800000, b=00000000 -> Exception=1, result=00000000.
  - a=7F800000, b=3F800000 -> Exception=1.
  - a=80000000, b=40A00000 -> zero=1, result=80000000.
  - In every case done occurs at E0+27.
- Range:
  - a=7F000000, b=3E800000 -> Overflow=1, result=7F800000.
  - a=00800000, b=7F000000 -> Underflow=1, result=00000000.
- Handshake:
  - start held high continuously -> accepts exactly every 29 cycles.
  - start pulsed during DIVIDE -> ignored; operands unchanged.
- Reset: assert rst at E0+10 for one cycle -> outputs 0 immediately (asynchronously), no done pulse follows; a new start afterwards completes normally in 28 cycles.
